// File: rtl/mips_pkg.sv
// Shared definitions for the MEM-stage SRAM path: board SRAM geometry,
// controller state encoding and width helpers.
`timescale 1ns/1ps
package mips_pkg;

  localparam int unsigned SRAM_DW = 16;
  localparam int unsigned SRAM_AW = 18;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Number of 16-bit SRAM beats per pipeline word.
  function automatic int unsigned beats_of(input int unsigned data_w);
    return data_w / SRAM_DW;
  endfunction

  // Counter width for a value range 0..v-1, never narrower than one bit.
  function automatic int unsigned min1_clog2(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/sram_mem_ctrl_beat_timer.sv
// Beat/cycle counters for one multi-beat SRAM access.
// Ports: clk, rst_n; i_start clears the counters; i_run advances them;
// o_beat is the current beat index; o_beat_last marks the final cycle of a
// beat; o_access_last marks the final cycle of the final beat.
`timescale 1ns/1ps
module sram_beat_timer
  import mips_pkg::*;
#(
  parameter int unsigned BEATS    = 1,
  parameter int unsigned BEAT_LEN = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_start,
  input  logic                             i_run,
  output logic [min1_clog2(BEATS)-1:0]     o_beat,
  output logic                             o_beat_last,
  output logic                             o_access_last
);

  localparam int unsigned CNT_W  = min1_clog2(BEAT_LEN);
  localparam int unsigned BEAT_W = min1_clog2(BEATS);

  logic [CNT_W-1:0]  r_cnt;
  logic [BEAT_W-1:0] r_beat;

  assign o_beat        = r_beat;
  assign o_beat_last   = (r_cnt == CNT_W'(BEAT_LEN - 1));
  assign o_access_last = o_beat_last && (r_beat == BEAT_W'(BEATS - 1));

  // cnt runs 0..BEAT_LEN-1 within a beat; beat steps at each beat end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_beat <= '0;
    end else if (i_start) begin
      r_cnt  <= '0;
      r_beat <= '0;
    end else if (i_run) begin
      if (o_beat_last) begin
        r_cnt <= '0;
        if (o_access_last) r_beat <= '0;
        else               r_beat <= r_beat + BEAT_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sram_mem_ctrl.sv
// MEM-stage SRAM controller: turns one load/store request into a timed
// multi-beat access on the 16-bit board SRAM and holds freeze until done.
// Ports: clk, rst_n; req_rd/req_wr/addr/wdata from EX/MEM; rdata/rvalid
// result; freeze pipeline hold; SRAM_* board SRAM pins (active-low strobes).
`timescale 1ns/1ps
module sram_mem_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_rd,
  input  logic               req_wr,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata,
  output logic               rvalid,
  output logic               freeze,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_CE_N
);

  localparam int unsigned BEATS    = beats_of(DATA_W);
  localparam int unsigned BEAT_LEN = WAIT_CYCLES + 1;
  localparam int unsigned BEAT_W   = min1_clog2(BEATS);

  state_t              r_state;
  state_t              w_next;
  logic                w_start;
  logic                w_run;
  logic                w_beat_last;
  logic                w_access_last;
  logic [BEAT_W-1:0]   w_beat;
  logic                w_dq_oe;
  logic [SRAM_DW-1:0]  w_dq_out;
  logic                r_op_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;

  sram_beat_timer #(
    .BEATS    (BEATS),
    .BEAT_LEN (BEAT_LEN)
  ) u_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (w_start),
    .i_run         (w_run),
    .o_beat        (w_beat),
    .o_beat_last   (w_beat_last),
    .o_access_last (w_access_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state and SRAM strobes; everything is a function of state so reset
  // releases the bus immediately.
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_run     = 1'b0;
    w_dq_oe   = 1'b0;
    freeze    = 1'b0;
    rvalid    = 1'b0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_UB_N = 1'b1;
    SRAM_LB_N = 1'b1;
    SRAM_CE_N = 1'b1;
    case (r_state)
      IDLE: begin
        if (req_wr || req_rd) begin
          freeze  = 1'b1;
          w_start = 1'b1;
          w_next  = ACCESS;
        end
      end
      ACCESS: begin
        freeze    = 1'b1;
        w_run     = 1'b1;
        SRAM_CE_N = 1'b0;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
        if (r_op_wr) begin
          w_dq_oe = 1'b1;
          // WE_N rises on the last cycle so address and data outlive it.
          SRAM_WE_N = w_beat_last;
        end else begin
          SRAM_OE_N = 1'b0;
        end
        if (w_access_last) w_next = DONE;
      end
      DONE: begin
        rvalid = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Request capture; write wins when both requests are present.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_wr <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_start) begin
      r_op_wr <= req_wr;
      r_addr  <= addr;
      r_wdata <= wdata;
    end
  end

  // Load data assembly, little-endian by beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (r_state == ACCESS && !r_op_wr && w_beat_last) begin
      for (int b = 0; b < BEATS; b++) begin
        if (w_beat == BEAT_W'(b)) r_rdata[b*SRAM_DW +: SRAM_DW] <= SRAM_DQ;
      end
    end
  end

  // Store data slice for the current beat.
  always_comb begin
    w_dq_out = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (w_beat == BEAT_W'(b)) w_dq_out = r_wdata[b*SRAM_DW +: SRAM_DW];
    end
  end

  assign rdata     = r_rdata;
  assign SRAM_DQ   = w_dq_oe ? w_dq_out : {SRAM_DW{1'bz}};
  // Wraps silently on the 18-bit SRAM address space.
  assign SRAM_ADDR = SRAM_AW'(32'(r_addr) * 32'(BEATS) + 32'(w_beat));

endmodule

// File: tb/tb_sram_mem_ctrl.sv
`timescale 1ns/1ps
module tb_sram_mem_ctrl;

  logic        clk;
  logic        rst_n;

  logic        a_req_rd, a_req_wr;
  logic [15:0] a_addr, a_wdata;
  logic [15:0] a_rdata;
  logic        a_rvalid, a_freeze;
  wire  [15:0] a_dq;
  logic [17:0] a_sram_addr;
  logic        a_we_n, a_oe_n, a_ub_n, a_lb_n, a_ce_n;

  logic        b_req_rd, b_req_wr;
  logic [15:0] b_addr;
  logic [63:0] b_wdata;
  logic [63:0] b_rdata;
  logic        b_rvalid, b_freeze;
  wire  [15:0] b_dq;
  logic [17:0] b_sram_addr;
  logic        b_we_n, b_oe_n, b_ub_n, b_lb_n, b_ce_n;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem_a [0:262143];
  logic [15:0] mem_b [0:262143];

  sram_mem_ctrl u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_rd(a_req_rd), .req_wr(a_req_wr),
    .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata), .rvalid(a_rvalid),
    .freeze(a_freeze), .SRAM_DQ(a_dq), .SRAM_ADDR(a_sram_addr),
    .SRAM_WE_N(a_we_n), .SRAM_OE_N(a_oe_n), .SRAM_UB_N(a_ub_n),
    .SRAM_LB_N(a_lb_n), .SRAM_CE_N(a_ce_n)
  );

  sram_mem_ctrl #(.DATA_W(64), .ADDR_W(16), .WAIT_CYCLES(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_rd(b_req_rd), .req_wr(b_req_wr),
    .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata), .rvalid(b_rvalid),
    .freeze(b_freeze), .SRAM_DQ(b_dq), .SRAM_ADDR(b_sram_addr),
    .SRAM_WE_N(b_we_n), .SRAM_OE_N(b_oe_n), .SRAM_UB_N(b_ub_n),
    .SRAM_LB_N(b_lb_n), .SRAM_CE_N(b_ce_n)
  );

  // Behavioural SRAMs: asynchronous read, write on WE_N rising edge.
  assign a_dq = (!a_ce_n && !a_oe_n && a_we_n) ? mem_a[a_sram_addr] : 16'bz;
  assign b_dq = (!b_ce_n && !b_oe_n && b_we_n) ? mem_b[b_sram_addr] : 16'bz;

  always @(posedge a_we_n) if (a_ce_n === 1'b0) mem_a[a_sram_addr] <= a_dq;
  always @(posedge b_we_n) if (b_ce_n === 1'b0) mem_b[b_sram_addr] <= b_dq;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sample(input bit sel, output bit fz, output bit rv, output bit ce,
                        output bit we, output bit oe, output logic [17:0] sa);
    if (!sel) begin
      fz = a_freeze; rv = a_rvalid; ce = a_ce_n | a_ub_n | a_lb_n;
      we = a_we_n; oe = a_oe_n; sa = a_sram_addr;
    end else begin
      fz = b_freeze; rv = b_rvalid; ce = b_ce_n | b_ub_n | b_lb_n;
      we = b_we_n; oe = b_oe_n; sa = b_sram_addr;
    end
  endtask

  // One request, held through DONE and dropped on the edge that leaves DONE.
  task automatic access(input bit sel, input bit wr, input bit rd,
                        input logic [15:0] ad, input logic [63:0] wd,
                        output int nfz, output int nrv,
                        output logic [17:0] fa, output logic [17:0] la,
                        output bit we_low, output bit oe_low, output bit idle_bad);
    bit fz, rv, ce, we, oe, seen;
    logic [17:0] sa;
    @(negedge clk);
    if (!sel) begin
      a_req_wr = wr; a_req_rd = rd; a_addr = ad; a_wdata = wd[15:0];
    end else begin
      b_req_wr = wr; b_req_rd = rd; b_addr = ad; b_wdata = wd;
    end
    nfz = 0; nrv = 0; seen = 1'b0; we_low = 1'b0; oe_low = 1'b0;
    idle_bad = 1'b0; fa = '0; la = '0;
    for (int c = 0; c < 60; c++) begin
      #1;
      sample(sel, fz, rv, ce, we, oe, sa);
      if (fz) nfz++;
      if (!ce) begin
        if (!seen) fa = sa;
        seen = 1'b1;
        la = sa;
      end
      if (!we) we_low = 1'b1;
      if (!oe) oe_low = 1'b1;
      if (rv) begin
        nrv++;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    a_req_wr = 1'b0; a_req_rd = 1'b0; b_req_wr = 1'b0; b_req_rd = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      sample(sel, fz, rv, ce, we, oe, sa);
      if (rv) nrv++;
      if (fz || !ce) idle_bad = 1'b1;
    end
  endtask

  initial begin
    int nfz, nrv;
    logic [17:0] fa, la;
    bit we_low, oe_low, idle_bad, found;
    logic [63:0] v64;
    logic [63:0] v_wrap;

    v64    = 64'h0123_4567_89AB_CDEF;
    v_wrap = 64'hA5A5_5A5A_F00D_CAFE;
    rst_n = 1'b0;
    a_req_rd = 1'b0; a_req_wr = 1'b0; a_addr = '0; a_wdata = '0;
    b_req_rd = 1'b0; b_req_wr = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_rdata_a", 64'(a_rdata), 64'h0);
    chk("rst_rdata_b", b_rdata, 64'h0);
    chk("rst_rvalid", 64'(a_rvalid), 64'h0);
    chk("rst_freeze", 64'(a_freeze), 64'h0);
    chk("rst_addr", 64'(a_sram_addr), 64'h0);
    chk("rst_strobes_a", 64'({a_we_n, a_oe_n, a_ub_n, a_lb_n, a_ce_n}), 64'h1F);
    chk("rst_strobes_b", 64'({b_we_n, b_oe_n, b_ub_n, b_lb_n, b_ce_n}), 64'h1F);
    a_req_rd = 1'b1;
    #1;
    chk("rst_freeze_req", 64'(a_freeze), 64'h1);
    chk("rst_no_rvalid_req", 64'(a_rvalid), 64'h0);
    a_req_rd = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Default params: store 5 <- BEEF.
    access(1'b0, 1'b1, 1'b0, 16'd5, 64'hBEEF, nfz, nrv, fa, la, we_low, oe_low, idle_bad);
    chk("a_st_freeze", 64'(nfz), 64'd3);
    chk("a_st_rvalid", 64'(nrv), 64'd1);
    chk("a_st_addr", 64'(fa), 64'd5);
    chk("a_st_we", 64'(we_low), 64'd1);
    chk("a_st_mem", 64'(mem_a[5]), 64'hBEEF);
    chk("a_st_rdata", 64'(a_rdata), 64'h0);
    chk("a_st_idle", 64'(idle_bad), 64'd0);

    // Load 5 back; request held through DONE.
    access(1'b0, 1'b0, 1'b1, 16'd5, 64'h0, nfz, nrv, fa, la, we_low, oe_low, idle_bad);
    chk("a_ld_freeze", 64'(nfz), 64'd3);
    chk("a_ld_rvalid", 64'(nrv), 64'd1);
    chk("a_ld_addr", 64'(la), 64'd5);
    chk("a_ld_rdata", 64'(a_rdata), 64'hBEEF);
    chk("a_ld_oe", 64'({we_low, oe_low}), 64'b01);
    chk("a_ld_idle", 64'(idle_bad), 64'd0);

    // Read and write together: write wins.
    access(1'b0, 1'b1, 1'b1, 16'd7, 64'h1234, nfz, nrv, fa, la, we_low, oe_low, idle_bad);
    chk("a_both_we_oe", 64'({we_low, oe_low}), 64'b10);
    chk("a_both_mem", 64'(mem_a[7]), 64'h1234);
    chk("a_both_rdata", 64'(a_rdata), 64'hBEEF);
    chk("a_both_rvalid", 64'(nrv), 64'd1);

    // 64-bit, 2 wait states: store 3.
    access(1'b1, 1'b1, 1'b0, 16'd3, v64, nfz, nrv, fa, la, we_low, oe_low, idle_bad);
    chk("b_st_freeze", 64'(nfz), 64'd13);
    chk("b_st_rvalid", 64'(nrv), 64'd1);
    chk("b_st_addr_range", 64'({fa, la}), {28'd0, 18'd12, 18'd15});
    chk("b_st_mem12", 64'(mem_b[12]), 64'hCDEF);
    chk("b_st_mem13", 64'(mem_b[13]), 64'h89AB);
    chk("b_st_mem14", 64'(mem_b[14]), 64'h4567);
    chk("b_st_mem15", 64'(mem_b[15]), 64'h0123);
    chk("b_st_idle", 64'(idle_bad), 64'd0);

    access(1'b1, 1'b0, 1'b1, 16'd3, 64'h0, nfz, nrv, fa, la, we_low, oe_low, idle_bad);
    chk("b_ld_freeze", 64'(nfz), 64'd13);
    chk("b_ld_rdata", b_rdata, v64);
    chk("b_ld_rvalid", 64'(nrv), 64'd1);

    // Reset during beat 2 of a 4-beat load.
    @(negedge clk);
    b_req_rd = 1'b1; b_addr = 16'd3;
    found = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      #1;
      if (b_ce_n == 1'b0 && b_sram_addr == 18'd14) begin
        found = 1'b1;
        break;
      end
    end
    chk("b_rst_beat2_reached", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("b_rst_strobes", 64'({b_we_n, b_oe_n, b_ub_n, b_lb_n, b_ce_n}), 64'h1F);
    chk("b_rst_rdata", b_rdata, 64'h0);
    chk("b_rst_rvalid", 64'(b_rvalid), 64'h0);
    b_req_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nrv = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (b_rvalid || b_freeze) nrv++;
    end
    chk("b_rst_quiet", 64'(nrv), 64'd0);
    chk("b_rst_rdata_after", b_rdata, 64'h0);

    access(1'b1, 1'b0, 1'b1, 16'd3, 64'h0, nfz, nrv, fa, la, we_low, oe_low, idle_bad);
    chk("b_reld_rdata", b_rdata, v64);
    chk("b_reld_freeze", 64'(nfz), 64'd13);
    chk("b_reld_rvalid", 64'(nrv), 64'd1);

    // Address wrap at the top of the 18-bit space.
    access(1'b1, 1'b1, 1'b0, 16'hFFFF, v_wrap, nfz, nrv, fa, la, we_low, oe_low, idle_bad);
    chk("b_wrap_addr_range", 64'({fa, la}), {28'd0, 18'h3FFFC, 18'h3FFFF});
    chk("b_wrap_rvalid", 64'(nrv), 64'd1);
    chk("b_wrap_mem_lo", 64'(mem_b[18'h3FFFC]), 64'hCAFE);
    chk("b_wrap_mem_hi", 64'(mem_b[18'h3FFFF]), 64'hA5A5);
    access(1'b1, 1'b0, 1'b1, 16'hFFFF, 64'h0, nfz, nrv, fa, la, we_low, oe_low, idle_bad);
    chk("b_wrap_rdata", b_rdata, v_wrap);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
